// File: rtl/stream_fifo_sync.sv
// stream_fifo_sync: single-clock ready/valid FIFO with fill level, synchronous flush
// and optional fall-through of the source beat when empty.
module stream_fifo_sync #(
    parameter int unsigned WIDTH        = 1,
    parameter type         T            = logic [WIDTH-1:0],
    parameter int unsigned LOG_DEPTH    = 3,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  T                   src_data_i,
    input  logic               src_valid_i,
    output logic               src_ready_o,
    output T                   dst_data_o,
    output logic               dst_valid_o,
    input  logic               dst_ready_i,
    output logic [LOG_DEPTH:0] usage_o
);
    localparam int unsigned DEPTH = 2**LOG_DEPTH;
    logic [LOG_DEPTH:0] wptr_q, rptr_q;
    T mem [DEPTH];
    logic empty, full, bypass_avail, bypass, push, pop;
    always_comb begin
        empty        = wptr_q == rptr_q;
        full         = (wptr_q ^ rptr_q) == {1'b1, {LOG_DEPTH{1'b0}}};
        bypass_avail = FALL_THROUGH & empty & src_valid_i;
        bypass       = bypass_avail & dst_ready_i;
        src_ready_o  = !full & !flush_i;
        dst_valid_o  = (!empty | bypass_avail) & !flush_i;
        dst_data_o   = bypass_avail ? src_data_i : mem[rptr_q[LOG_DEPTH-1:0]];
        push         = src_valid_i & src_ready_o & !bypass;
        pop          = dst_valid_o & dst_ready_i & !empty;
        usage_o      = wptr_q - rptr_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (LOG_DEPTH+1)'(1);
            if (pop) rptr_q <= rptr_q + (LOG_DEPTH+1)'(1);
        end
    end
    // Storage is deliberately unreset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q[LOG_DEPTH-1:0]] <= src_data_i;
    end
endmodule

// File: tb/tb_stream_fifo_sync.sv
// tb_stream_fifo_sync: directed vectors on a registered and a fall-through instance,
// with per-instance scoreboards checking output order.
module tb_stream_fifo_sync;
    logic clk, rst_n;
    logic f0, sv0, sr0, dv0, dr0, f1, sv1, sr1, dv1, dr1;
    logic [7:0] sd0, dd0, sd1, dd1;
    logic [2:0] u0, u1;
    int errors = 0, checks = 0;
    logic [7:0] q0[$], q1[$];

    stream_fifo_sync #(.WIDTH(8), .LOG_DEPTH(2), .FALL_THROUGH(1'b0)) d0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f0), .src_data_i(sd0), .src_valid_i(sv0),
        .src_ready_o(sr0), .dst_data_o(dd0), .dst_valid_o(dv0), .dst_ready_i(dr0), .usage_o(u0));
    stream_fifo_sync #(.WIDTH(8), .LOG_DEPTH(2), .FALL_THROUGH(1'b1)) d1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .src_data_i(sd1), .src_valid_i(sv1),
        .src_ready_o(sr1), .dst_data_o(dd1), .dst_valid_o(dv1), .dst_ready_i(dr1), .usage_o(u1));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: accepted beats are queued, presented-and-taken beats are compared.
    always @(negedge clk) begin
        if (!rst_n || f0) q0.delete();
        else begin
            if (sv0 && sr0) q0.push_back(sd0);
            if (dv0 && dr0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d0_extra: got %0h expected nothing", dd0);
                end else chk("d0_data", {24'd0, dd0}, {24'd0, q0.pop_front()});
            end
        end
    end
    always @(negedge clk) begin
        if (!rst_n || f1) q1.delete();
        else begin
            if (sv1 && sr1) q1.push_back(sd1);
            if (dv1 && dr1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d1_extra: got %0h expected nothing", dd1);
                end else chk("d1_data", {24'd0, dd1}, {24'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] fill [4];
        fill = '{8'hA, 8'hB, 8'hC, 8'hD};
        rst_n = 0; f0 = 0; sv0 = 0; dr0 = 0; sd0 = 0; f1 = 0; sv1 = 0; dr1 = 0; sd1 = 0;
        tick; tick;
        chk("rst_usage", u0, 0);
        chk("rst_ready", sr0, 1);
        chk("rst_valid", dv0, 0);
        sv1 = 1; #1;
        chk("rst_ft_valid", dv1, 1);
        sv1 = 0;
        tick;
        rst_n = 1;
        tick;
        chk("post_rst_usage", u0, 0);
        chk("post_rst_ready", sr0, 1);

        // fill and drain
        sv0 = 1;
        for (int i = 0; i < 4; i++) begin
            sd0 = fill[i];
            tick;
        end
        sv0 = 0;
        chk("fill_ready", sr0, 0);
        chk("fill_usage", u0, 4);
        chk("fill_head", dd0, 8'hA);
        dr0 = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_usage", u0, 4 - i);
            tick;
        end
        chk("drain_usage_end", u0, 0);
        chk("drain_valid_end", dv0, 0);

        // streaming across pointer wrap
        sv0 = 1;
        for (int i = 0; i < 20; i++) begin
            sd0 = 8'(i);
            tick;
            chk("stream_usage", u0, 1);
            chk("stream_head", dd0, i);
        end
        sv0 = 0;
        tick;
        chk("stream_end_usage", u0, 0);

        // full with simultaneous pop
        dr0 = 0; sv0 = 1;
        for (int i = 0; i < 4; i++) begin
            sd0 = 8'h10 + 8'(i);
            tick;
        end
        dr0 = 1; sd0 = 8'h14; #1;
        chk("full_pop_ready", sr0, 0);
        tick;
        chk("full_pop_usage", u0, 3);
        chk("full_pop_ready_next", sr0, 1);
        tick;
        chk("full_pop_accept_usage", u0, 3);
        sv0 = 0;
        tick; tick; tick;
        chk("full_drain_usage", u0, 0);
        chk("full_drain_valid", dv0, 0);
        dr0 = 0;

        // fall-through
        sv1 = 1; sd1 = 8'h5; dr1 = 1; #1;
        chk("ft_valid", dv1, 1);
        chk("ft_data", dd1, 8'h5);
        tick;
        chk("ft_usage", u1, 0);
        dr1 = 0;
        tick;
        sv1 = 0;
        chk("ft_store_usage", u1, 1);
        chk("ft_store_valid", dv1, 1);
        chk("ft_store_data", dd1, 8'h5);
        dr1 = 1;
        tick;
        chk("ft_pop_usage", u1, 0);
        dr1 = 0;

        // flush
        sv0 = 1;
        for (int i = 0; i < 3; i++) begin
            sd0 = 8'h21 + 8'(i);
            tick;
        end
        chk("pre_flush_usage", u0, 3);
        f0 = 1; sd0 = 8'h24; #1;
        chk("flush_ready", sr0, 0);
        chk("flush_valid", dv0, 0);
        tick;
        f0 = 0; sv0 = 0;
        chk("post_flush_usage", u0, 0);
        chk("post_flush_valid", dv0, 0);
        sv0 = 1; sd0 = 8'h7;
        tick;
        sv0 = 0; dr0 = 1; #1;
        chk("post_flush_data", dd0, 8'h7);
        chk("post_flush_data_valid", dv0, 1);
        tick;
        chk("post_flush_drained", u0, 0);
        dr0 = 0;

        // asynchronous reset between edges
        sv0 = 1;
        for (int i = 0; i < 2; i++) begin
            sd0 = 8'h31 + 8'(i);
            tick;
        end
        sv0 = 0;
        chk("pre_arst_usage", u0, 2);
        #2 rst_n = 0; #1;
        chk("arst_usage", u0, 0);
        chk("arst_valid", dv0, 0);
        @(negedge clk); #1;
        tick;
        rst_n = 1; #1;
        chk("arst_rel_usage", u0, 0);
        chk("arst_rel_ready", sr0, 1);
        chk("arst_rel_valid", dv0, 0);
        tick;

        chk("sb0_left", q0.size(), 0);
        chk("sb1_left", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
